// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle instruction sequencer
// Steps FETCH/DECODE/EXECUTE/MEM/WRITEBACK, with a sticky FAULT state and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned COUNT_W        = 16,
  parameter logic [3:0]  ALU_ADD        = 4'b0001,
  parameter logic [3:0]  ALU_SUB        = 4'b0010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         opcode,
  input  logic               branch_taken,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic [3:0]         alu_operation_type,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               retire,
  output logic [COUNT_W-1:0] instr_count,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_BRANCH = 4'b0011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [COUNT_W-1:0]  r_instr_count;

  logic       w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_write, w_pc_write, w_pc_src;
  logic [3:0] w_alu_op;
  logic       w_reg_write, w_wb_sel, w_retire, w_fault, w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      // Count only stalled cycles of a memory access; any other cycle leaves it at zero for the next entry.
      if ((r_state == S_FETCH || r_state == S_MEM) && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_pc_src       = 1'b0;
    w_alu_op       = 4'b0000;
    w_reg_write    = 1'b0;
    w_wb_sel       = 1'b0;
    w_retire       = 1'b0;
    w_fault        = 1'b0;
    w_timeout      = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == WAIT_LAST) && !mem_ready;

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_next = (opcode[3:2] == 2'b00) ? S_EXECUTE : S_FAULT;
      end
      S_EXECUTE: begin
        case (opcode)
          OP_ADD: begin
            w_alu_op = ALU_ADD;
            w_next   = S_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_op = ALU_ADD;
            w_next   = S_MEM;
          end
          OP_BRANCH: begin
            w_alu_op   = ALU_SUB;
            w_pc_src   = 1'b1;
            w_pc_write = branch_taken;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_FAULT;
        endcase
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          w_retire = (opcode == OP_STORE);
          w_next   = (opcode == OP_STORE) ? S_FETCH : S_WRITEBACK;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        w_reg_write = 1'b1;
        w_wb_sel    = (opcode == OP_LOAD);
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_FAULT: begin
        w_fault = 1'b1;
      end
      default: w_next = S_FAULT;
    endcase
  end

  assign mem_req            = w_mem_req & ~reset;
  assign mem_we             = w_mem_we & ~reset;
  assign mem_addr_sel       = w_mem_addr_sel & ~reset;
  assign ir_write           = w_ir_write & ~reset;
  assign pc_write           = w_pc_write & ~reset;
  assign pc_src             = w_pc_src & ~reset;
  assign alu_operation_type = reset ? 4'b0000 : w_alu_op;
  assign reg_write          = w_reg_write & ~reset;
  assign wb_sel             = w_wb_sel & ~reset;
  assign retire             = w_retire & ~reset;
  assign instr_count        = reset ? '0 : r_instr_count;
  assign fault              = w_fault & ~reset;
  assign state              = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - bench for multicycle_control_fsm
// Expected per-cycle traces are expanded from instruction descriptions {opcode, fetch waits, mem waits, taken}.
module tb_multicycle_control_fsm;

  localparam logic [3:0] OP_ADD = 4'd0, OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_BRANCH = 4'd3;
  localparam logic [3:0] A_ADD = 4'b0001, A_SUB = 4'b0010;
  localparam int TMO = 16;

  typedef struct packed {
    logic [2:0] st;
    logic req, we, asel, irw, pcw, pcs;
    logic [3:0] alu;
    logic rw, wbs, ret, flt;
  } outs_t;

  typedef struct packed {
    logic rdy;
    logic bt;
    logic [3:0] op;
    outs_t exp;
  } cyc_t;

  typedef struct {
    logic [3:0] op;
    int wf;
    int wm;
    logic bt;
    int lat;
    string name;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, branch_taken = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel, retire, fault;
  logic [3:0] alu_operation_type;
  logic [15:0] instr_count;
  logic [2:0] state;
  logic u_req, u_we, u_asel, u_irw, u_pcw, u_pcs, u_rw, u_wbs, u_ret, u_flt;
  logic [3:0] u_alu, cnt_small;
  logic [2:0] u_st;
  outs_t act;

  cyc_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int unsigned cnt_model = 0;
  logic [3:0] g_op = 4'd0;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_operation_type(alu_operation_type),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .instr_count(instr_count),
    .fault(fault), .state(state)
  );

  // Narrow counter copy so the wrap from all-ones to zero is reached within a short run.
  multicycle_control_fsm #(.COUNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(u_req), .mem_we(u_we), .mem_addr_sel(u_asel), .ir_write(u_irw),
    .pc_write(u_pcw), .pc_src(u_pcs), .alu_operation_type(u_alu),
    .reg_write(u_rw), .wb_sel(u_wbs), .retire(u_ret), .instr_count(cnt_small),
    .fault(u_flt), .state(u_st)
  );

  assign act = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                alu_operation_type, reg_write, wb_sel, retire, fault};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, got, want);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c.rdy    = 1'($urandom);
    c.bt     = 1'($urandom);
    c.op     = g_op;
    c.exp    = '0;
    c.exp.st = st;
    return c;
  endfunction

  task automatic add_fault(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(3'd5);
      c.exp.flt = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  task automatic add_instr(input logic [3:0] op, input int wf, input int wm, input logic bt);
    cyc_t c;
    g_op = op;
    for (int i = 0; i < wf && i < TMO; i++) begin
      c = mk(3'd0); c.rdy = 1'b0; c.exp.req = 1'b1;
      exp_q.push_back(c);
    end
    if (wf >= TMO) begin add_fault(3); return; end
    c = mk(3'd0); c.rdy = 1'b1; c.exp.req = 1'b1; c.exp.irw = 1'b1; c.exp.pcw = 1'b1;
    exp_q.push_back(c);
    exp_q.push_back(mk(3'd1));
    if (op > OP_BRANCH) begin add_fault(20); return; end
    c = mk(3'd2);
    if (op == OP_BRANCH) begin
      c.bt = bt; c.exp.alu = A_SUB; c.exp.pcs = 1'b1; c.exp.pcw = bt; c.exp.ret = 1'b1;
      exp_q.push_back(c);
      return;
    end
    c.exp.alu = A_ADD;
    exp_q.push_back(c);
    if (op != OP_ADD) begin
      for (int i = 0; i < wm && i < TMO; i++) begin
        c = mk(3'd3); c.rdy = 1'b0; c.exp.req = 1'b1; c.exp.asel = 1'b1; c.exp.we = (op == OP_STORE);
        exp_q.push_back(c);
      end
      if (wm >= TMO) begin add_fault(3); return; end
      c = mk(3'd3); c.rdy = 1'b1; c.exp.req = 1'b1; c.exp.asel = 1'b1;
      c.exp.we = (op == OP_STORE); c.exp.ret = (op == OP_STORE);
      exp_q.push_back(c);
      if (op == OP_STORE) return;
    end
    c = mk(3'd4); c.exp.rw = 1'b1; c.exp.wbs = (op == OP_LOAD); c.exp.ret = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic run_q(input string name, output int ret_at);
    ret_at = -1;
    foreach (exp_q[i]) begin
      @(negedge clk);
      reset = 1'b0;
      mem_ready = exp_q[i].rdy;
      branch_taken = exp_q[i].bt;
      opcode = exp_q[i].op;
      #1;
      check({name, " outputs"}, i, {15'b0, act}, {15'b0, exp_q[i].exp});
      check({name, " instr_count"}, i, 32'(instr_count), cnt_model % 65536);
      check({name, " instr_count_4b"}, i, 32'(cnt_small), cnt_model % 16);
      if (retire && ret_at < 0) ret_at = i + 1;
      if (exp_q[i].exp.ret) cnt_model++;
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input int prev_st, input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      if (i > 0 || prev_st >= 0) begin
        e = '0;
        e.st = (i == 0) ? 3'(prev_st) : 3'd0;
        check("reset outputs", i, {15'b0, act}, {15'b0, e});
        check("reset instr_count", i, 32'(instr_count), 32'd0);
      end
    end
    cnt_model = 0;
  endtask

  initial begin
    vec_t tbl[9];
    int r, op, wf, wm, lat;

    tbl[0] = '{OP_ADD,    0,  0, 1'b0, 4,  "T1 add"};
    tbl[1] = '{OP_LOAD,   0,  3, 1'b0, 8,  "T2 load 3 waits"};
    tbl[2] = '{OP_STORE,  0,  0, 1'b0, 4,  "T3 store"};
    tbl[3] = '{OP_BRANCH, 0,  0, 1'b1, 3,  "T3 branch taken"};
    tbl[4] = '{OP_BRANCH, 0,  0, 1'b0, 3,  "T3 branch not taken"};
    tbl[5] = '{OP_LOAD,   0,  0, 1'b0, 5,  "load zero wait"};
    tbl[6] = '{OP_STORE,  2,  2, 1'b0, 8,  "store waits"};
    tbl[7] = '{OP_ADD,    15, 0, 1'b0, 19, "T5 ready on last fetch cycle"};
    tbl[8] = '{OP_LOAD,   0,  15, 1'b0, 20, "load ready on last mem cycle"};

    do_reset(-1, 2);

    foreach (tbl[i]) begin
      add_instr(tbl[i].op, tbl[i].wf, tbl[i].wm, tbl[i].bt);
      run_q(tbl[i].name, r);
      check({tbl[i].name, " latency"}, i, r, tbl[i].lat);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("count after table", 0, 32'(instr_count), 32'd9);

    add_instr(4'b0111, 0, 0, 1'b0);
    run_q("T4 illegal opcode", r);
    do_reset(5, 1);

    add_instr(OP_ADD, TMO, 0, 1'b0);
    run_q("T5 fetch timeout", r);
    do_reset(5, 1);

    add_instr(OP_LOAD, 0, TMO, 1'b0);
    run_q("mem timeout", r);
    do_reset(5, 1);

    add_instr(OP_LOAD, 0, TMO, 1'b0);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    run_q("T6 load before reset", r);
    do_reset(3, 1);
    add_instr(OP_ADD, 0, 0, 1'b0);
    run_q("T6 add after reset", r);
    check("T6 add latency", 0, r, 4);

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 3));
      wf = int'($urandom_range(0, 3));
      wm = int'($urandom_range(0, 3));
      add_instr(4'(op), wf, wm, 1'($urandom));
      case (op)
        0: lat = 4 + wf;
        1: lat = 5 + wf + wm;
        2: lat = 4 + wf + wm;
        default: lat = 3 + wf;
      endcase
      run_q("random", r);
      check("random latency", k, r, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
